spart_tx_sched: RTL and testbench
=================================

# spart_tx_sched

Transmit-side controller for the SPART serial port. Shares the byte transmitter among `NREQ` requesters with round-robin arbitration, and sequences every bus access to it. Programs the baud-rate divisor after reset and on request. Sits between on-chip byte sources and the SPART bus (`iocs`/`iorw`/`ioaddr`/`databus`).

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DIV_INIT`, default 16'd325: baud divisor written after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NREQ  per-requester send request (level).
- `data_in`  in  8*NREQ  byte for requester i at bits [8i+7:8i].
- `gnt`  out  NREQ  one-cycle accept pulse, one-hot or zero.
- `div_wr`  in  1  pulse: load `div_in` as the new divisor.
- `div_in`  in  16  new divisor value.
- `tbr`  in  1  transmit buffer ready from SPART (1 = can accept a byte).
- `iocs`  out  1  SPART chip select.
- `iorw`  out  1  1 = read, 0 = write.
- `ioaddr`  out  2  00 TX buffer, 10 divisor low, 11 divisor high.
- `databus`  out  8  write data to SPART.
- `busy`  out  1  high whenever state ≠ IDLE.
- `cfg_done`  out  1  divisor programmed, no reconfiguration pending.

## Operation
- States: INIT, CFG_LO, CFG_HI, IDLE, SEND, GUARD. The bus outputs are a Moore decode of the registered state.
  - When `iocs` = 0, the bus outputs are `iorw` = 1, `ioaddr` = 00, `databus` = 8'h00.
- INIT: bus idle. Next state is CFG_LO unconditionally.
- CFG_LO: `iocs` = 1, `iorw` = 0, `ioaddr` = 10, `databus` = div_reg[7:0]. Next state is CFG_HI.
- CFG_HI: same, with `ioaddr` = 11 and `databus` = div_reg[15:8]. Clears `cfg_pend`. Next state is IDLE.
- IDLE: bus idle. Decisions are made with `tbr` sampled this cycle.
  - `cfg_pend` = 1 and `tbr` = 1 → CFG_LO. Reconfiguration beats data requests.
  - Otherwise, `tbr` = 1 and `req` ≠ 0 → round-robin pick of winner w.
    - Search starts at `last` + 1 (mod NREQ).
    - Assert `gnt[w]` this cycle.
    - Latch `data_in[w]` into `tx_byte` and set `last` = w.
    - Next state is SEND.
  - Otherwise stay in IDLE.
- SEND: `iocs` = 1, `iorw` = 0, `ioaddr` = 00, `databus` = `tx_byte` for exactly one cycle. Next state is GUARD.
- GUARD: one idle bus cycle so the SPART can drop `tbr`. Next state is IDLE.
- `div_wr` is accepted in any state, including during reset-sequence configuration.
  - It loads `div_reg` ← `div_in` and sets `cfg_pend`.
  - Last write wins.
  - `div_wr` in the CFG_HI cycle takes precedence over the clear, so `cfg_pend` stays set.
- `cfg_done` = 1 when state ∉ {INIT, CFG_LO, CFG_HI} and `cfg_pend` = 0.
- Requesters hold `req` and `data_in` stable until `gnt`, then drop `req` the next cycle. `req` is sampled only in IDLE, so a late drop cannot cause a double send.

## Timing
- Reset values: state INIT, `last` = NREQ-1 (requester 0 wins first), `div_reg` = DIV_INIT, `cfg_pend` = 0, `tx_byte` = 0.
  - While `rst` is high: `gnt` = 0, `iocs` = 0, `iorw` = 1, `ioaddr` = 00, `databus` = 00, `busy` = 1, `cfg_done` = 0.
- After `rst` deasserts, the divisor-low write is on the bus in cycle 1 and the high write in cycle 2. The earliest grant is in cycle 3.
- Grant to SEND latency is 1 cycle. Minimum spacing between SEND cycles is 3 cycles, and is otherwise limited by `tbr`.
- `tbr` = 0 in IDLE blocks both grants and reconfiguration. Requests wait indefinitely; there is no timeout.
- Reset mid-SEND or mid-CFG aborts the access. The next cycle shows an idle bus, and the full reset sequence re-runs.
- Only one `gnt` bit is ever set, and it is never set outside IDLE.

## Test plan
- Reset release, `tbr` = 1, no requests → cycle 1: `ioaddr` = 10, `databus` = 8'h45; cycle 2: `ioaddr` = 11, `databus` = 8'h01; then IDLE with `cfg_done` = 1, `busy` = 0.
- `req` = 4'b0001, `data_in[7:0]` = 8'hA5 → `gnt` = 0001 for one cycle, then one SEND cycle with `ioaddr` = 00, `iorw` = 0, `databus` = A5, then GUARD.
- `req` = 4'b1111 held, `tbr` toggled low for 20 cycles after each SEND → grant order 0, 1, 2, 3, 0, with no grant while `tbr` = 0.
- `div_wr` with `div_in` = 16'h00A2 while a byte is shifting (`tbr` = 0), `req[2]` also pending → after `tbr` rises: CFG_LO A2, CFG_HI 00 first, then `gnt[2]`.
- `rst` asserted during SEND → bus idles the next cycle, `tx_byte` is not resent, reset sequence re-runs with DIV_INIT, first grant goes to requester 0.
- `div_wr` twice (16'h0010 then 16'h0020) before IDLE is reached → a single CFG pair is written, with value 0020.

Source files
------------

// File: rtl/spart_tx_sched.sv
// spart_tx_sched: shares the SPART byte transmitter among NREQ requesters with
// round-robin arbitration and sequences every divisor and TX-buffer bus write.
module spart_tx_sched #(
    parameter int          NREQ     = 4,
    parameter logic [15:0] DIV_INIT = 16'd325
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data_in,
    output logic [NREQ-1:0]   gnt,
    input  logic              div_wr,
    input  logic [15:0]       div_in,
    input  logic              tbr,
    output logic              iocs,
    output logic              iorw,
    output logic [1:0]        ioaddr,
    output logic [7:0]        databus,
    output logic              busy,
    output logic              cfg_done
);

    localparam int LW = $clog2(NREQ);

    typedef enum logic [2:0] {
        INIT,
        CFG_LO,
        CFG_HI,
        IDLE,
        SEND,
        GUARD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   last;
    logic [15:0]     div_reg;
    logic            cfg_pend;
    logic [7:0]      tx_byte;
    logic [2*NREQ-1:0] rot;
    logic [LW-1:0]   winner;
    logic            grant_fire;
    int              offset;
    int              pick;

    // Rotate the request vector so the search starts just after the last winner.
    assign rot = {req, req} >> (int'(last) + 1);

    // Round-robin winner: first requester found after the previous winner.
    always_comb begin
        offset = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = i;
            end
        end
        pick = int'(last) + 1 + offset;
        if (pick >= NREQ) begin
            pick = pick - NREQ;
        end
        winner = LW'(pick);
    end

    // A grant happens only from IDLE, with the transmitter ready and no reconfiguration queued.
    assign grant_fire = !rst && (state == IDLE) && tbr && !cfg_pend && (|req);

    // One-hot accept pulse toward the winning requester.
    always_comb begin
        gnt = '0;
        if (grant_fire) begin
            gnt[winner] = 1'b1;
        end
    end

    // State register; reset always restarts the divisor programming sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; reconfiguration takes priority over data when tbr allows.
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    state_nxt = CFG_LO;
            CFG_LO:  state_nxt = CFG_HI;
            CFG_HI:  state_nxt = IDLE;
            IDLE: begin
                if (tbr && cfg_pend) begin
                    state_nxt = CFG_LO;
                end else if (tbr && (|req)) begin
                    state_nxt = SEND;
                end
            end
            SEND:    state_nxt = GUARD;
            GUARD:   state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // Divisor, pending-reconfiguration flag, arbitration pointer and latched byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= LW'(NREQ - 1);
            div_reg  <= DIV_INIT;
            cfg_pend <= 1'b0;
            tx_byte  <= 8'h00;
        end else begin
            if (div_wr) begin
                div_reg  <= div_in;
                cfg_pend <= 1'b1;
            end else if (state == CFG_HI) begin
                cfg_pend <= 1'b0;
            end
            if (grant_fire) begin
                last    <= winner;
                tx_byte <= data_in[8*winner +: 8];
            end
        end
    end

    // Moore bus decode; the bus is forced idle while reset is held.
    always_comb begin
        iocs    = 1'b0;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        databus = 8'h00;
        if (!rst) begin
            case (state)
                CFG_LO: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b10;
                    databus = div_reg[7:0];
                end
                CFG_HI: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b11;
                    databus = div_reg[15:8];
                end
                SEND: begin
                    iocs    = 1'b1;
                    iorw    = 1'b0;
                    ioaddr  = 2'b00;
                    databus = tx_byte;
                end
                default: begin
                    iocs    = 1'b0;
                end
            endcase
        end
    end

    // Status flags for the surrounding system.
    assign busy     = rst || (state != IDLE);
    assign cfg_done = !rst && !cfg_pend &&
                      ((state == IDLE) || (state == SEND) || (state == GUARD));

endmodule

// File: tb/tb_spart_tx_sched.sv
// tb_spart_tx_sched: directed self-checking bench for the SPART transmit scheduler.
module tb_spart_tx_sched;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic        div_wr;
    logic [15:0] div_in;
    logic        tbr;
    logic        iocs;
    logic        iorw;
    logic [1:0]  ioaddr;
    logic [7:0]  databus;
    logic        busy;
    logic        cfg_done;

    int          checks = 0;
    int          failures = 0;
    logic [3:0]  g;
    logic        saw;

    spart_tx_sched #(.NREQ(NREQ), .DIV_INIT(16'd325)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .busy     (busy),
        .cfg_done (cfg_done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkBus(input string tag, input int cs, input int addr, input int data);
        checkOutput({tag, "_iocs"}, 32'(iocs), 32'(cs));
        checkOutput({tag, "_iorw"}, 32'(iorw), (cs != 0) ? 32'd0 : 32'd1);
        checkOutput({tag, "_ioaddr"}, 32'(ioaddr), 32'(addr));
        checkOutput({tag, "_databus"}, 32'(databus), 32'(data));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic t, input logic dw, input logic [15:0] dv);
        req    = r;
        tbr    = t;
        div_wr = dw;
        div_in = dv;
        #1;
    endtask

    task automatic waitGrant(input int max_cycles, output logic [3:0] got);
        got = '0;
        for (int n = 0; n < max_cycles; n++) begin
            if (gnt != 4'b0000) begin
                got = gnt;
                return;
            end
            nextCycle();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
        nextCycle();
        nextCycle();
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkBus("rst", 0, 0, 0);
        checkOutput("rst_busy", 32'(busy), 32'h1);
        checkOutput("rst_cfg_done", 32'(cfg_done), 32'h0);
        rst = 1'b0;
        #1;
        checkBus("init", 0, 0, 0);
        checkOutput("init_busy", 32'(busy), 32'h1);
        nextCycle();
        checkBus("cfg_lo", 1, 2, 'h45);
        nextCycle();
        checkBus("cfg_hi", 1, 3, 'h01);
        nextCycle();
        checkBus("idle", 0, 0, 0);
        checkOutput("idle_busy", 32'(busy), 32'h0);
        checkOutput("idle_cfg_done", 32'(cfg_done), 32'h1);
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        data_in = '0;
        div_wr  = 1'b0;
        div_in  = '0;
        tbr     = 1'b1;

        // Reset release and default divisor programming.
        doReset();

        // Single request from requester 0.
        data_in = 32'h0000_00A5;
        applyStimulus(4'b0001, 1'b1, 1'b0, 16'h0000);
        checkOutput("single_gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
        checkBus("single_send", 1, 0, 'hA5);
        checkOutput("single_send_gnt", 32'(gnt), 32'h0);
        checkOutput("single_send_busy", 32'(busy), 32'h1);
        nextCycle();
        checkBus("single_guard", 0, 0, 0);
        checkOutput("single_guard_busy", 32'(busy), 32'h1);
        nextCycle();
        checkOutput("single_idle_busy", 32'(busy), 32'h0);

        // Round-robin order with all requesters held and tbr pulled low after each send.
        doReset();
        data_in = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
        applyStimulus(4'b1111, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            waitGrant(10, g);
            checkOutput($sformatf("rr_gnt%0d", i), 32'(g), 32'(1) << (i % 4));
            nextCycle();
            tbr = 1'b0;
            #1;
            checkOutput($sformatf("rr_send%0d", i), 32'(databus), 32'hB0 + 32'(i % 4));
            saw = 1'b0;
            for (int c = 0; c < 20; c++) begin
                nextCycle();
                if (gnt != 4'b0000) saw = 1'b1;
            end
            checkOutput($sformatf("rr_hold%0d", i), 32'(saw), 32'h0);
            req = (i == 4) ? 4'b0000 : 4'b1111;
            tbr = 1'b1;
            #1;
        end

        // Reconfiguration queued while tbr is low beats a pending data request.
        data_in = {8'hD3, 8'hC2, 8'h77, 8'h5A};
        applyStimulus(4'b0100, 1'b0, 1'b1, 16'h00A2);
        checkOutput("pend_gnt", 32'(gnt), 32'h0);
        nextCycle();
        applyStimulus(4'b0100, 1'b0, 1'b0, 16'h0000);
        checkOutput("pend_cfg_done", 32'(cfg_done), 32'h0);
        saw = 1'b0;
        for (int c = 0; c < 5; c++) begin
            nextCycle();
            if (iocs || (gnt != 4'b0000)) saw = 1'b1;
        end
        checkOutput("pend_blocked", 32'(saw), 32'h0);
        applyStimulus(4'b0100, 1'b1, 1'b0, 16'h0000);
        checkOutput("pend_first_gnt", 32'(gnt), 32'h0);
        nextCycle();
        checkBus("recfg_lo", 1, 2, 'hA2);
        nextCycle();
        checkBus("recfg_hi", 1, 3, 'h00);
        nextCycle();
        checkOutput("recfg_gnt", 32'(gnt), 32'h4);
        checkOutput("recfg_cfg_done", 32'(cfg_done), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
        checkBus("send_c2", 1, 0, 'hC2);
        nextCycle();
        nextCycle();

        // Reset asserted during SEND aborts the access and restarts the sequence.
        applyStimulus(4'b1000, 1'b1, 1'b0, 16'h0000);
        checkOutput("abort_gnt", 32'(gnt), 32'h8);
        nextCycle();
        checkBus("abort_send", 1, 0, 'hD3);
        rst = 1'b1;
        applyStimulus(4'b1001, 1'b1, 1'b0, 16'h0000);
        checkBus("abort_rst", 0, 0, 0);
        checkOutput("abort_rst_gnt", 32'(gnt), 32'h0);
        nextCycle();
        rst = 1'b0;
        #1;
        checkBus("abort_init", 0, 0, 0);
        checkOutput("abort_init_cfg_done", 32'(cfg_done), 32'h0);
        nextCycle();
        checkBus("abort_lo", 1, 2, 'h45);
        nextCycle();
        checkBus("abort_hi", 1, 3, 'h01);
        nextCycle();
        checkOutput("abort_first_gnt", 32'(gnt), 32'h1);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
        checkBus("send_5a", 1, 0, 'h5A);
        nextCycle();
        nextCycle();

        // Two divisor writes before IDLE collapse into one configuration pair.
        applyStimulus(4'b0010, 1'b1, 1'b0, 16'h0000);
        checkOutput("dbl_gnt", 32'(gnt), 32'h2);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b1, 16'h0010);
        checkBus("dbl_send", 1, 0, 'h77);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b1, 16'h0020);
        checkOutput("dbl_guard_cfg_done", 32'(cfg_done), 32'h0);
        nextCycle();
        applyStimulus(4'b0000, 1'b1, 1'b0, 16'h0000);
        checkBus("dbl_idle", 0, 0, 0);
        nextCycle();
        checkBus("dbl_lo", 1, 2, 'h20);
        nextCycle();
        checkBus("dbl_hi", 1, 3, 'h00);
        nextCycle();
        checkBus("dbl_after", 0, 0, 0);
        checkOutput("dbl_cfg_done", 32'(cfg_done), 32'h1);
        checkOutput("dbl_busy", 32'(busy), 32'h0);
        nextCycle();
        checkOutput("dbl_no_second", 32'(iocs), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
